// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: stall/flush sequencer for the 5-stage RV32 pipeline.
// Handles load-use hazards, multi-cycle mul/div occupancy of EX, dmem-wait
// freeze, and branch/trap flushes. Control outputs are combinational from
// the registered state and the current inputs, and are forced to 0 while
// rst_n is low.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   id_rs1/rs2_addr, id_uses_rs1/2  source operands of the ID instruction
//   ex_mem_read, ex_rd_addr         load-in-EX detection
//   ex_md_valid, md_done            multi-cycle unit handshake
//   branch_taken, trap_flush        redirect requests
//   mem_req, mem_ready              dmem wait
//   pc_stall .. ex_mem_bubble       per-stage stall/bubble/flush controls
//   md_start, md_abort              multi-cycle unit control pulses
//   perf_stall_cnt                  count of cycles with pc_stall=1
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   defined   -> perf_stall_cnt is a free-running 32-bit stall counter
//   undefined -> perf_stall_cnt is tied to 0
module hazard_ctrl_unit #(
    parameter int unsigned LOAD_USE_CYCLES = 1,
    parameter int unsigned MD_TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_md_valid,
    input  logic        md_done,
    input  logic        branch_taken,
    input  logic        trap_flush,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_stall,
    output logic        id_ex_bubble,
    output logic        ex_mem_stall,
    output logic        ex_mem_bubble,
    output logic        md_start,
    output logic        md_abort,
    output logic [31:0] perf_stall_cnt
);

    localparam int unsigned LU_CNT_W = 2;
    localparam int unsigned MD_CNT_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MD_BUSY  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [LU_CNT_W-1:0]   lu_cnt_q, lu_cnt_d;
    logic [MD_CNT_W-1:0]   md_cnt_q, md_cnt_d;

    logic mem_freeze;
    logic load_use_hit;
    logic md_timeout_hit;

    logic pc_stall_c, if_id_stall_c, if_id_flush_c, id_ex_stall_c, id_ex_bubble_c;
    logic ex_mem_stall_c, ex_mem_bubble_c, md_start_c, md_abort_c;

    assign mem_freeze   = mem_req && !mem_ready;
    assign load_use_hit = ex_mem_read && (ex_rd_addr != 5'd0) &&
                          ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                           (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));
    // md_cnt counts unfrozen cycles since md_start (the start cycle is 1)
    assign md_timeout_hit = (MD_TIMEOUT != 0) &&
                            (md_cnt_q == MD_CNT_W'(MD_TIMEOUT - 1));

    // Next-state and control decode, priority trap > freeze > branch > MD > load-use
    always_comb begin
        state_d         = state_q;
        lu_cnt_d        = lu_cnt_q;
        md_cnt_d        = md_cnt_q;
        pc_stall_c      = 1'b0;
        if_id_stall_c   = 1'b0;
        if_id_flush_c   = 1'b0;
        id_ex_stall_c   = 1'b0;
        id_ex_bubble_c  = 1'b0;
        ex_mem_stall_c  = 1'b0;
        ex_mem_bubble_c = 1'b0;
        md_start_c      = 1'b0;
        md_abort_c      = 1'b0;

        if (trap_flush) begin
            if_id_flush_c   = 1'b1;
            id_ex_bubble_c  = 1'b1;
            ex_mem_bubble_c = 1'b1;
            md_abort_c      = (state_q == ST_MD_BUSY);
            state_d         = ST_RUN;
            lu_cnt_d        = '0;
            md_cnt_d        = '0;
        end else if (mem_freeze) begin
            // whole pipe holds; branch/md_done are left for the upstream to repeat
            pc_stall_c     = 1'b1;
            if_id_stall_c  = 1'b1;
            id_ex_stall_c  = 1'b1;
            ex_mem_stall_c = 1'b1;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (branch_taken) begin
                        if_id_flush_c  = 1'b1;
                        id_ex_bubble_c = 1'b1;
                    end else if (ex_md_valid) begin
                        md_start_c      = 1'b1;
                        ex_mem_bubble_c = 1'b1;
                        pc_stall_c      = 1'b1;
                        if_id_stall_c   = 1'b1;
                        id_ex_stall_c   = 1'b1;
                        md_cnt_d        = MD_CNT_W'(1);
                        state_d         = ST_MD_BUSY;
                    end else if (load_use_hit) begin
                        pc_stall_c     = 1'b1;
                        if_id_stall_c  = 1'b1;
                        id_ex_bubble_c = 1'b1;
                        if (LOAD_USE_CYCLES > 1) begin
                            lu_cnt_d = LU_CNT_W'(LOAD_USE_CYCLES - 1);
                            state_d  = ST_LU_STALL;
                        end
                    end
                end
                ST_LU_STALL: begin
                    if (branch_taken) begin
                        if_id_flush_c  = 1'b1;
                        id_ex_bubble_c = 1'b1;
                        lu_cnt_d       = '0;
                        state_d        = ST_RUN;
                    end else begin
                        pc_stall_c     = 1'b1;
                        if_id_stall_c  = 1'b1;
                        id_ex_bubble_c = 1'b1;
                        lu_cnt_d       = lu_cnt_q - LU_CNT_W'(1);
                        if (lu_cnt_q == LU_CNT_W'(1)) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_MD_BUSY: begin
                    if (md_done) begin
                        // result advances out of EX this cycle
                        md_cnt_d = '0;
                        state_d  = ST_RUN;
                    end else if (md_timeout_hit) begin
                        md_abort_c = 1'b1;
                        md_cnt_d   = '0;
                        state_d    = ST_RUN;
                    end else begin
                        pc_stall_c      = 1'b1;
                        if_id_stall_c   = 1'b1;
                        id_ex_stall_c   = 1'b1;
                        ex_mem_bubble_c = 1'b1;
                        md_cnt_d        = md_cnt_q + MD_CNT_W'(1);
                    end
                end
                default: begin
                    state_d  = ST_RUN;
                    lu_cnt_d = '0;
                    md_cnt_d = '0;
                end
            endcase
        end
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            lu_cnt_q <= '0;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            lu_cnt_q <= lu_cnt_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // Outputs are held at 0 for the whole reset assertion
    assign pc_stall      = pc_stall_c      & rst_n;
    assign if_id_stall   = if_id_stall_c   & rst_n;
    assign if_id_flush   = if_id_flush_c   & rst_n;
    assign id_ex_stall   = id_ex_stall_c   & rst_n;
    assign id_ex_bubble  = id_ex_bubble_c  & rst_n;
    assign ex_mem_stall  = ex_mem_stall_c  & rst_n;
    assign ex_mem_bubble = ex_mem_bubble_c & rst_n;
    assign md_start      = md_start_c      & rst_n;
    assign md_abort      = md_abort_c      & rst_n;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_cnt_q, perf_cnt_d;

    // Stall-cycle counter, wraps naturally at 2^32
    always_comb begin
        perf_cnt_d = perf_cnt_q + 32'(pc_stall_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt_q <= '0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
        end
    end

    assign perf_stall_cnt = perf_cnt_q;
`else
    assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Testbench for hazard_ctrl_unit: two instances with different parameters
// share one stimulus stream; a cycle-level behavioural model predicts the
// control vector and stall count of each.
module tb_hazard_ctrl_unit;

    localparam int LU_A = 1;
    localparam int TO_A = 8;
    localparam int LU_B = 3;
    localparam int TO_B = 0;

    // control vector bit positions
    localparam int B_PC  = 8;
    localparam int B_IFS = 7;
    localparam int B_IFF = 6;
    localparam int B_IDS = 5;
    localparam int B_IDB = 4;
    localparam int B_EXS = 3;
    localparam int B_EXB = 2;
    localparam int B_MST = 1;
    localparam int B_MAB = 0;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_md_valid, md_done;
    logic branch_taken, trap_flush, mem_req, mem_ready;

    logic a_pc, a_ifs, a_iff, a_ids, a_idb, a_exs, a_exb, a_mst, a_mab;
    logic b_pc, b_ifs, b_iff, b_ids, b_idb, b_exs, b_exb, b_mst, b_mab;
    logic [31:0] perf_a, perf_b;
    logic [8:0]  ctl_a, ctl_b;

    assign ctl_a = {a_pc, a_ifs, a_iff, a_ids, a_idb, a_exs, a_exb, a_mst, a_mab};
    assign ctl_b = {b_pc, b_ifs, b_iff, b_ids, b_idb, b_exs, b_exb, b_mst, b_mab};

    hazard_ctrl_unit #(.LOAD_USE_CYCLES(LU_A), .MD_TIMEOUT(TO_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
        .ex_md_valid(ex_md_valid), .md_done(md_done),
        .branch_taken(branch_taken), .trap_flush(trap_flush),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_stall(a_pc), .if_id_stall(a_ifs), .if_id_flush(a_iff),
        .id_ex_stall(a_ids), .id_ex_bubble(a_idb),
        .ex_mem_stall(a_exs), .ex_mem_bubble(a_exb),
        .md_start(a_mst), .md_abort(a_mab), .perf_stall_cnt(perf_a)
    );

    hazard_ctrl_unit #(.LOAD_USE_CYCLES(LU_B), .MD_TIMEOUT(TO_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
        .ex_md_valid(ex_md_valid), .md_done(md_done),
        .branch_taken(branch_taken), .trap_flush(trap_flush),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_stall(b_pc), .if_id_stall(b_ifs), .if_id_flush(b_iff),
        .id_ex_stall(b_ids), .id_ex_bubble(b_idb),
        .ex_mem_stall(b_exs), .ex_mem_bubble(b_exb),
        .md_start(b_mst), .md_abort(b_mab), .perf_stall_cnt(perf_b)
    );

    always #5 clk = ~clk;

    // Model state: remaining extra load-use stall cycles, whether a mul/div
    // occupies EX and for how many unfrozen cycles, and stall cycles so far.
    typedef struct {
        int          lu_left;
        bit          md_active;
        int          md_age;
        logic [31:0] perf;
    } mdl_t;

    mdl_t m_a, m_b;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.lu_left   = 0;
        m.md_active = 1'b0;
        m.md_age    = 0;
        m.perf      = 32'd0;
        return m;
    endfunction

    function automatic logic [31:0] exp_perf(input mdl_t m);
`ifdef HAZARD_PERF_CNT_EN
        return m.perf;
`else
        return (m.perf & 32'd0);
`endif
    endfunction

    task automatic model_eval(input int lu_cyc, input int tmo, input mdl_t cur,
                              output logic [8:0] e, output mdl_t nxt);
        bit hazard, freeze;
        nxt    = cur;
        e      = '0;
        hazard = ex_mem_read && (ex_rd_addr != 0) &&
                 ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) ||
                  (id_uses_rs2 && id_rs2_addr == ex_rd_addr));
        freeze = mem_req && !mem_ready;
        if (trap_flush) begin
            e[B_IFF] = 1'b1; e[B_IDB] = 1'b1; e[B_EXB] = 1'b1;
            e[B_MAB] = cur.md_active;
            nxt.lu_left = 0; nxt.md_active = 1'b0; nxt.md_age = 0;
        end else if (freeze) begin
            e[B_PC] = 1'b1; e[B_IFS] = 1'b1; e[B_IDS] = 1'b1; e[B_EXS] = 1'b1;
        end else if (cur.md_active) begin
            if (md_done || (tmo != 0 && cur.md_age == tmo - 1)) begin
                e[B_MAB] = !md_done;
                nxt.md_active = 1'b0; nxt.md_age = 0;
            end else begin
                e[B_PC] = 1'b1; e[B_IFS] = 1'b1; e[B_IDS] = 1'b1; e[B_EXB] = 1'b1;
                nxt.md_age = cur.md_age + 1;
            end
        end else if (branch_taken) begin
            e[B_IFF] = 1'b1; e[B_IDB] = 1'b1;
            nxt.lu_left = 0;
        end else if (cur.lu_left > 0) begin
            e[B_PC] = 1'b1; e[B_IFS] = 1'b1; e[B_IDB] = 1'b1;
            nxt.lu_left = cur.lu_left - 1;
        end else if (ex_md_valid) begin
            e[B_MST] = 1'b1; e[B_EXB] = 1'b1;
            e[B_PC] = 1'b1; e[B_IFS] = 1'b1; e[B_IDS] = 1'b1;
            nxt.md_active = 1'b1; nxt.md_age = 1;
        end else if (hazard) begin
            e[B_PC] = 1'b1; e[B_IFS] = 1'b1; e[B_IDB] = 1'b1;
            nxt.lu_left = lu_cyc - 1;
        end
        nxt.perf = cur.perf + 32'(e[B_PC]);
    endtask

    task automatic set_idle();
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_rd_addr = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_md_valid = 1'b0; md_done = 1'b0; branch_taken = 1'b0;
        trap_flush = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic rand_inputs();
        id_rs1_addr  = 5'($urandom_range(0, 3));
        id_rs2_addr  = 5'($urandom_range(0, 3));
        ex_rd_addr   = 5'($urandom_range(0, 3));
        id_uses_rs1  = ($urandom_range(0, 3) != 0);
        id_uses_rs2  = ($urandom_range(0, 1) != 0);
        ex_mem_read  = ($urandom_range(0, 2) == 0);
        ex_md_valid  = ($urandom_range(0, 9) == 0);
        md_done      = ($urandom_range(0, 9) == 0);
        branch_taken = ($urandom_range(0, 11) == 0);
        trap_flush   = ($urandom_range(0, 39) == 0);
        mem_req      = ($urandom_range(0, 3) == 0);
        mem_ready    = ($urandom_range(0, 1) == 0);
    endtask

    // Compare current-cycle outputs at the falling edge, then advance the model
    task automatic step();
        logic [8:0] ea, eb;
        mdl_t na, nb;
        @(negedge clk);
        model_eval(LU_A, TO_A, m_a, ea, na);
        model_eval(LU_B, TO_B, m_b, eb, nb);
        check_eq($sformatf("ctl_a@%0d", cyc), 64'(ctl_a), 64'(ea));
        check_eq($sformatf("ctl_b@%0d", cyc), 64'(ctl_b), 64'(eb));
        check_eq($sformatf("perf_a@%0d", cyc), 64'(perf_a), 64'(exp_perf(m_a)));
        check_eq($sformatf("perf_b@%0d", cyc), 64'(perf_b), 64'(exp_perf(m_b)));
        @(posedge clk);
        m_a = na;
        m_b = nb;
        cyc++;
        #1;
    endtask

    task automatic check_reset_zero(input string tag);
        check_eq({tag, "_ctl_a"}, 64'(ctl_a), 64'd0);
        check_eq({tag, "_ctl_b"}, 64'(ctl_b), 64'd0);
        check_eq({tag, "_perf_a"}, 64'(perf_a), 64'd0);
        check_eq({tag, "_perf_b"}, 64'(perf_b), 64'd0);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) begin
            set_idle();
            step();
        end
    endtask

    initial begin
        m_a = mdl_reset();
        m_b = mdl_reset();
        set_idle();
        rst_n = 1'b0;
        // Outputs stay 0 under reset whatever the inputs request
        for (int i = 0; i < 4; i++) begin
            rand_inputs();
            trap_flush  = (i == 0);
            ex_md_valid = 1'b1;
            #3;
            check_reset_zero($sformatf("rst%0d", i));
        end
        set_idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        idle_steps(2);

        // load x5 in EX, add x6,x5,x1 in ID
        ex_mem_read = 1'b1; ex_rd_addr = 5'd5;
        id_uses_rs1 = 1'b1; id_rs1_addr = 5'd5; id_uses_rs2 = 1'b1; id_rs2_addr = 5'd1;
        step();
        idle_steps(4);

        // same pattern targeting x0 never stalls
        ex_mem_read = 1'b1; ex_rd_addr = 5'd0;
        id_uses_rs1 = 1'b1; id_rs1_addr = 5'd0;
        step();

        // load x7 hazard coinciding with a taken branch
        set_idle();
        ex_mem_read = 1'b1; ex_rd_addr = 5'd7;
        id_uses_rs2 = 1'b1; id_rs2_addr = 5'd7; branch_taken = 1'b1;
        step();
        idle_steps(2);

        // mul/div finishing 5 cycles after start
        for (int i = 0; i < 6; i++) begin
            set_idle();
            ex_md_valid = 1'b1;
            md_done     = (i == 5);
            step();
        end
        idle_steps(2);

        // mul/div that never finishes: instance A aborts at cycle 7
        for (int i = 0; i < 10; i++) begin
            set_idle();
            ex_md_valid = 1'b1;
            step();
        end
        set_idle();
        trap_flush = 1'b1;
        step();
        idle_steps(2);

        // MD busy, 3-cycle dmem freeze, then trap
        for (int i = 0; i < 7; i++) begin
            set_idle();
            ex_md_valid = (i < 3);
            mem_req     = (i >= 3) && (i < 6);
            trap_flush  = (i == 6);
            step();
        end
        idle_steps(2);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step();
        end

        // reset in the middle of MD busy
        set_idle();
        ex_md_valid = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        #2;
        check_reset_zero("rst_mid_md");
        @(negedge clk);
        set_idle();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_a = mdl_reset();
        m_b = mdl_reset();
        step();
        ex_md_valid = 1'b1;
        step();
        set_idle();
        md_done = 1'b1;
        step();
        idle_steps(1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Central stall/flush sequencer for the 5-stage RV32 pipeline. It sits beside forwarding, which covers every RAW case except load-use.
- Detects load-use hazards.
- Sequences multi-cycle mul/div occupancy of EX.
- Freezes the pipe on data-memory wait.
- Flushes on taken branches and traps.
Drives per-stage stall/bubble/flush controls of the PC and the IF/ID, ID/EX, EX/MEM pipeline registers.

Parameters:
LOAD_USE_CYCLES, 1, total stall cycles per load-use hazard (1..3)
MD_TIMEOUT, 64, max cycles in MD_BUSY before forced abort (0 = no timeout)

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
id_rs1_addr  input  5  rs1 of instruction in ID
id_rs2_addr  input  5  rs2 of instruction in ID
id_uses_rs1  input  1  ID instruction reads rs1
id_uses_rs2  input  1  ID instruction reads rs2 (incl. store data)
ex_mem_read  input  1  EX instruction is a load
ex_rd_addr  input  5  rd of EX instruction
ex_md_valid  input  1  EX holds a mul/div needing the multi-cycle unit
md_done  input  1  multi-cycle unit result valid (1-cycle pulse)
branch_taken  input  1  EX resolved a taken branch/jump
trap_flush  input  1  exception/trap redirect, flush all
mem_req  input  1  MEM stage has an outstanding dmem access
mem_ready  input  1  dmem completes access this cycle
pc_stall  output  1  hold PC
if_id_stall  output  1  hold IF/ID
if_id_flush  output  1  clear IF/ID to NOP
id_ex_stall  output  1  hold ID/EX
id_ex_bubble  output  1  load NOP into ID/EX
ex_mem_stall  output  1  hold EX/MEM
ex_mem_bubble  output  1  load NOP into EX/MEM
md_start  output  1  start pulse to multi-cycle unit
md_abort  output  1  abort pulse to multi-cycle unit
perf_stall_cnt  output  32  stall-cycle counter (see Optional Feature)

Behaviour:
- States: RUN, LU_STALL, MD_BUSY. Registered state plus down-counter lu_cnt and up-counter md_cnt; outputs combinational from state and inputs.
- Reset: state=RUN, counters 0. While rst_n low every output is 0.
- Priority (highest first): trap_flush > mem freeze > branch_taken > MD > load-use.
- trap_flush: if_id_flush=1, id_ex_bubble=1, ex_mem_bubble=1. If in MD_BUSY, md_abort=1. Next state RUN, counters cleared. Applies in any state.
- Mem freeze: mem_req && !mem_ready.
  - pc_stall=if_id_stall=id_ex_stall=ex_mem_stall=1.
  - State and counters hold; md_cnt does not advance.
  - No bubble/flush/md_start issued.
  - A branch_taken or md_done arriving during freeze is not consumed. The upstream must hold it (EX is frozen).
- branch_taken (RUN only): if_id_flush=1, id_ex_bubble=1 for that cycle. Suppresses a simultaneous load-use detection (wrong path).
- MD (RUN, ex_md_valid):
  - md_start=1 for one cycle; ex_mem_bubble=1; pc/if_id/id_ex stall=1; go MD_BUSY.
  - MD_BUSY: pc/if_id/id_ex stall=1, ex_mem_bubble=1, md_cnt++.
  - md_done in MD_BUSY: stalls drop that cycle, EX result advances, ex_mem_bubble=0, go RUN.
  - md_done while not in MD_BUSY is ignored.
  - MD_TIMEOUT>0 and md_cnt reaches MD_TIMEOUT-1 without md_done: md_abort=1, go RUN. The EX instruction then advances with an undefined result; the trap path handles it.
- Load-use (RUN, no higher event):
  - Hazard = ex_mem_read && ex_rd_addr!=0 && ((id_uses_rs1 && rs1==rd) || (id_uses_rs2 && rs2==rd)).
  - Hazard cycle: pc_stall=1, if_id_stall=1, id_ex_bubble=1.
  - If LOAD_USE_CYCLES>1: lu_cnt=LOAD_USE_CYCLES-1, go LU_STALL.
  - LU_STALL: same outputs, lu_cnt-- each cycle, RUN when lu_cnt reaches 0 (after the decrement).
  - x0 never hazards.
- branch_taken in LU_STALL: flush as in RUN, go RUN.
- md_start is never reasserted while in MD_BUSY.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: perf_stall_cnt increments every cycle with pc_stall=1. Cleared by reset, wraps at 2^32.
- Undefined: perf_stall_cnt tied to 0 and no counter register is inferred.

Test Plan:
- Load x5 in EX, ID add x6,x5,x1, LOAD_USE_CYCLES=1 -> one cycle of pc_stall=if_id_stall=id_ex_bubble=1, then all 0. Same with rd=x0 -> no stall.
- ex_mem_read rd=x7 with branch_taken in the same cycle -> if_id_flush=id_ex_bubble=1, pc_stall=0, state stays RUN.
- ex_md_valid, md_done after 5 cycles -> md_start pulse in cycle 0; stalls + ex_mem_bubble for cycles 0-4; cycle 5 all 0; state RUN.
- MD_TIMEOUT=8, md_done never -> md_abort=1 exactly at cycle 7 after md_start, then RUN.
- MD_BUSY, then mem_req=1/mem_ready=0 for 3 cycles, then trap_flush -> 3 cycles of full freeze with md_cnt held. Next cycle: md_abort=1, if_id_flush=id_ex_bubble=ex_mem_bubble=1, state RUN.
- HAZARD_PERF_CNT_EN defined, 1 load-use + 5-cycle MD -> perf_stall_cnt=6; rst_n low mid-MD_BUSY -> all outputs 0, counter 0, state RUN.
